// File: rtl/ftdi_pixel_writer_pkg.sv
// rtl/ftdi_pixel_writer_pkg.sv - shared types and constants for the FTDI pixel writer
//
// Purpose: reader FSM state encoding, byte-framing bit positions and the
// byte-phase constants shared by the unpacker and the top level.
package ftdi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TURN = 2'd1,
      READ = 2'd2,
      FULL = 2'd3
   } state_t;

   localparam int START_BIT   = 7;
   localparam int SOF_BIT     = 6;
   localparam int PIXEL_BYTES = 3;
   localparam int PIXEL_W     = 20;

   localparam logic [1:0] PH_B0 = 2'd0;
   localparam logic [1:0] PH_B1 = 2'd1;
   localparam logic [1:0] PH_B2 = 2'(PIXEL_BYTES - 1);

endpackage

// File: rtl/ftdi_pixel_unpacker.sv
// rtl/ftdi_pixel_unpacker.sv - reassembles 3-byte groups into 20-bit pixels
//
// Purpose: tracks the byte phase and applies the framing rules. The pixel and
// its valid/error flags are combinational so the caller can register them on
// the same edge that transfers the final byte.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         return to the B0 phase (frame swap)
//   byte_valid_i    byte_i is transferred on this edge
//   byte_i          received byte
//   pix_valid_o     this edge completes a pixel (B2 accepted)
//   pix_o, sof_o    completed pixel and its start-of-frame flag
//   sync_err_o      this byte violates the framing
module ftdi_pixel_unpacker
   import ftdi_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               byte_valid_i,
   input  logic [7:0]         byte_i,
   output logic               pix_valid_o,
   output logic [PIXEL_W-1:0] pix_o,
   output logic               sof_o,
   output logic               sync_err_o
);

   logic [1:0] phase_q, phase_d;
   logic [6:0] b0_q, b0_d;   // {sof, d[19:14]}
   logic [6:0] b1_q, b1_d;   // d[13:7]
   logic       start_bit;

   assign start_bit = byte_i[START_BIT];

   always_comb begin
      phase_d     = phase_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      pix_valid_o = 1'b0;
      sync_err_o  = 1'b0;
      if (clear_i) begin
         phase_d = PH_B0;
      end else if (byte_valid_i) begin
         if (start_bit) begin
            // A start byte always opens a new pixel; mid-pixel it also
            // discards the partial one.
            sync_err_o = (phase_q != PH_B0);
            b0_d       = byte_i[6:0];
            phase_d    = PH_B1;
         end else begin
            case (phase_q)
               PH_B0: sync_err_o = 1'b1;
               PH_B1: begin
                  b1_d    = byte_i[6:0];
                  phase_d = PH_B2;
               end
               default: begin
                  pix_valid_o = 1'b1;
                  phase_d     = PH_B0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= PH_B0;
         b0_q    <= '0;
         b1_q    <= '0;
      end else begin
         phase_q <= phase_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
      end
   end

   assign sof_o = b0_q[SOF_BIT];
   assign pix_o = {b0_q[5:0], b1_q, byte_i[6:0]};

endmodule

// File: rtl/ftdi_pixel_writer.sv
// rtl/ftdi_pixel_writer.sv - FT232H 245-FIFO reader writing pixels into the back buffer
//
// Purpose: reads bytes from the FT232H, unpacks them into pixels and writes a
// frame sequentially into the framebuffer, then waits for the buffer swap.
// Ports:
//   clk_60, rst_n              60 MHz FTDI clock, asynchronous active-low reset
//   ftdi_data, ftdi_rxf_n      FT232H data and receive-data-available
//   ftdi_oe_n, ftdi_rd_n       FT232H output enable and read strobe (registered)
//   wdata, waddr, we           framebuffer write port, we is a one-cycle strobe
//   full_ftdi                  frame complete, waiting for the swap
//   swapped_ftdi               one-cycle swap confirmation
//   sync_err                   one-cycle pulse per framing error
module ftdi_pixel_writer
   import ftdi_pkg::*;
#(
   parameter int FRAME_PIXELS = 16384,
   parameter int ADDR_WIDTH   = 14
) (
   input  logic                  clk_60,
   input  logic                  rst_n,
   input  logic [7:0]            ftdi_data,
   input  logic                  ftdi_rxf_n,
   output logic                  ftdi_oe_n,
   output logic                  ftdi_rd_n,
   output logic [PIXEL_W-1:0]    wdata,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  we,
   output logic                  full_ftdi,
   input  logic                  swapped_ftdi,
   output logic                  sync_err
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   pix_cnt_q;
   logic                    synced_q;
   logic                    oe_n_q, rd_n_q, we_q, full_q, sync_err_q;
   logic [PIXEL_W-1:0]      wdata_q;
   logic [ADDR_WIDTH-1:0]   waddr_q;

   logic                    xfer, clear;
   logic                    pix_valid, pix_sof, unp_err;
   logic [PIXEL_W-1:0]      pix;
   logic                    wr_en, restart, last_wr;
   logic [ADDR_WIDTH-1:0]   wr_addr;

   // rd_n is low exactly in READ, so a transfer only needs the state and rxf_n.
   assign xfer  = (state_q == READ) && !ftdi_rxf_n;
   assign clear = (state_q == FULL) && swapped_ftdi;

   ftdi_pixel_unpacker u_unpacker (
      .clk_i        (clk_60),
      .rst_ni       (rst_n),
      .clear_i      (clear),
      .byte_valid_i (xfer),
      .byte_i       (ftdi_data),
      .pix_valid_o  (pix_valid),
      .pix_o        (pix),
      .sof_o        (pix_sof),
      .sync_err_o   (unp_err)
   );

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = pix_cnt_q;
      restart = 1'b0;
      if (xfer && pix_valid) begin
         if (pix_sof) begin
            // sof realigns the frame; an early sof inside a frame is an error.
            wr_en   = 1'b1;
            wr_addr = '0;
            restart = synced_q && (pix_cnt_q != '0);
         end else if (synced_q) begin
            wr_en = 1'b1;
         end
      end
   end

   assign last_wr = wr_en && (wr_addr == LAST_ADDR);

   always_ff @(posedge clk_60 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pix_cnt_q  <= '0;
         synced_q   <= 1'b0;
         oe_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         we_q       <= 1'b0;
         full_q     <= 1'b0;
         sync_err_q <= 1'b0;
         wdata_q    <= '0;
         waddr_q    <= '0;
      end else begin
         we_q       <= wr_en;
         sync_err_q <= unp_err || restart;
         if (wr_en) begin
            wdata_q <= pix;
            waddr_q <= wr_addr;
            if (pix_sof) synced_q <= 1'b1;
            // Hold at the last address; FULL blocks any further write.
            pix_cnt_q <= last_wr ? wr_addr : wr_addr + ADDR_WIDTH'(1);
         end
         case (state_q)
            IDLE: begin
               if (!ftdi_rxf_n) begin
                  state_q <= TURN;
                  oe_n_q  <= 1'b0;
               end
            end
            TURN: begin
               state_q <= READ;
               rd_n_q  <= 1'b0;
            end
            READ: begin
               if (last_wr) begin
                  state_q <= FULL;
                  oe_n_q  <= 1'b1;
                  rd_n_q  <= 1'b1;
                  full_q  <= 1'b1;
               end
            end
            FULL: begin
               if (swapped_ftdi) begin
                  state_q   <= IDLE;
                  full_q    <= 1'b0;
                  pix_cnt_q <= '0;
                  synced_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               oe_n_q  <= 1'b1;
               rd_n_q  <= 1'b1;
               full_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ftdi_oe_n = oe_n_q;
   assign ftdi_rd_n = rd_n_q;
   assign we        = we_q;
   assign full_ftdi = full_q;
   assign sync_err  = sync_err_q;
   assign wdata     = wdata_q;
   assign waddr     = waddr_q;

endmodule

// File: tb/tb_ftdi_pixel_writer.sv
// tb/tb_ftdi_pixel_writer.sv - self-checking bench for ftdi_pixel_writer
module tb_ftdi_pixel_writer;

   localparam int FP = 4;
   localparam int AW = 14;

   logic          clk_60 = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    ftdi_data = 8'h00;
   logic          ftdi_rxf_n = 1'b1;
   logic          ftdi_oe_n, ftdi_rd_n;
   logic [19:0]   wdata;
   logic [AW-1:0] waddr;
   logic          we, full_ftdi, sync_err;
   logic          swapped_ftdi = 1'b0;

   ftdi_pixel_writer #(.FRAME_PIXELS(FP), .ADDR_WIDTH(AW)) dut (
      .clk_60       (clk_60),
      .rst_n        (rst_n),
      .ftdi_data    (ftdi_data),
      .ftdi_rxf_n   (ftdi_rxf_n),
      .ftdi_oe_n    (ftdi_oe_n),
      .ftdi_rd_n    (ftdi_rd_n),
      .wdata        (wdata),
      .waddr        (waddr),
      .we           (we),
      .full_ftdi    (full_ftdi),
      .swapped_ftdi (swapped_ftdi),
      .sync_err     (sync_err)
   );

   always #5 clk_60 = ~clk_60;

   typedef struct {
      int          nb;
      logic [31:0] bytes;     // first byte in [31:24]
      int          pause;     // rxf_n high cycles after the first byte
      logic        exp_we;
      logic [13:0] exp_addr;
      logic [19:0] exp_data;
      int          exp_err;
   } vec_t;

   vec_t        vt[6];
   logic [7:0]  q[$];
   int          hold = 0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          we_seen, err_seen;
   logic        cur_we;
   logic [13:0] last_addr;
   logic [19:0] last_data;
   int          oe_fall = -1;
   int          rd_fall = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One clock: the FIFO model pops a byte when the edge transferred it,
   // outputs are sampled on the falling edge, then rxf_n/data are redriven.
   task automatic step();
      bit xf;
      xf = (ftdi_rd_n == 1'b0) && (ftdi_rxf_n == 1'b0);
      @(negedge clk_60);
      cyc++;
      if (xf && q.size() > 0) void'(q.pop_front());
      cur_we = we;
      if (we) begin
         we_seen++;
         last_addr = waddr;
         last_data = wdata;
      end
      if (sync_err) err_seen++;
      if (!ftdi_oe_n && oe_fall < 0) oe_fall = cyc;
      if (!ftdi_rd_n && rd_fall < 0) rd_fall = cyc;
      if (hold > 0) begin
         ftdi_rxf_n = 1'b1;
         hold--;
      end else if (q.size() > 0) begin
         ftdi_rxf_n = 1'b0;
         ftdi_data  = q[0];
      end else begin
         ftdi_rxf_n = 1'b1;
      end
   endtask

   task automatic wait_empty(input string name);
      for (int i = 0; i < 80 && q.size() > 0; i++) step();
      chk(name, q.size(), 0);
   endtask

   task automatic push_pixel(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      q.push_back(b0);
      q.push_back(b1);
      q.push_back(b2);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_oe_n"}, ftdi_oe_n, 1);
      chk({tag, "_rd_n"}, ftdi_rd_n, 1);
      chk({tag, "_we"}, we, 0);
      chk({tag, "_full"}, full_ftdi, 0);
      chk({tag, "_wdata"}, wdata, 0);
      chk({tag, "_waddr"}, waddr, 0);
      chk({tag, "_sync_err"}, sync_err, 0);
   endtask

   initial begin
      // Frame 1: leading sof=0 pixel, sof pixel, dropped byte, normal pixel,
      // start bit in place of B1, and a pixel with a pause inside it.
      vt[0] = '{3, 32'h81010200, 0, 1'b0, 14'd0, 20'h00000, 0};
      vt[1] = '{3, 32'hC52A7F00, 0, 1'b1, 14'd0, 20'h1557F, 0};
      vt[2] = '{1, 32'h12000000, 0, 1'b0, 14'd0, 20'h00000, 1};
      vt[3] = '{3, 32'h83112200, 0, 1'b1, 14'd1, 20'h0C8A2, 0};
      vt[4] = '{4, 32'h84851020, 0, 1'b1, 14'd2, 20'h14820, 1};
      vt[5] = '{3, 32'h8F7F0000, 5, 1'b1, 14'd3, 20'h3FF80, 0};

      repeat (3) step();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 6; i++) begin
         logic [31:0] bv;
         bv       = vt[i].bytes;
         we_seen  = 0;
         err_seen = 0;
         q.push_back(bv[31:24]);
         if (vt[i].pause > 0) begin
            wait_empty($sformatf("v%0d_drain_b0", i));
            hold = vt[i].pause;
         end
         for (int k = 1; k < vt[i].nb; k++) begin
            bv = bv << 8;
            q.push_back(bv[31:24]);
         end
         wait_empty($sformatf("v%0d_drain", i));
         chk($sformatf("v%0d_we_after_b2", i), cur_we, vt[i].exp_we);
         chk($sformatf("v%0d_we_count", i), we_seen, vt[i].exp_we ? 1 : 0);
         chk($sformatf("v%0d_sync_err", i), err_seen, vt[i].exp_err);
         if (vt[i].exp_we) begin
            chk($sformatf("v%0d_waddr", i), last_addr, vt[i].exp_addr);
            chk($sformatf("v%0d_wdata", i), last_data, vt[i].exp_data);
         end
      end

      chk("oe_before_rd", rd_fall - oe_fall, 1);
      chk("f1_full", full_ftdi, 1);
      chk("f1_rd_n_high", ftdi_rd_n, 1);
      chk("f1_oe_n_high", ftdi_oe_n, 1);

      // Frame 2: six pixels queued while FULL; exactly four are read.
      push_pixel(8'hC1, 8'h00, 8'h01);
      push_pixel(8'h81, 8'h00, 8'h02);
      push_pixel(8'h81, 8'h00, 8'h03);
      push_pixel(8'h81, 8'h00, 8'h04);
      push_pixel(8'h82, 8'h00, 8'h05);
      push_pixel(8'hC2, 8'h11, 8'h22);
      repeat (3) step();
      chk("full_holds_reads", q.size(), 18);
      chk("full_level", full_ftdi, 1);

      we_seen  = 0;
      err_seen = 0;
      swapped_ftdi = 1'b1;
      step();
      swapped_ftdi = 1'b0;
      chk("swap_full_low", full_ftdi, 0);
      chk("swap_idle_oe_n", ftdi_oe_n, 1);
      step();
      chk("turn_oe_n", ftdi_oe_n, 0);
      chk("turn_rd_n", ftdi_rd_n, 1);
      step();
      chk("read_rd_n", ftdi_rd_n, 0);
      for (int i = 0; i < 100 && !full_ftdi; i++) step();
      chk("f2_full", full_ftdi, 1);
      chk("f2_last_we_in_full", cur_we, 1);
      chk("f2_rd_n_rose", ftdi_rd_n, 1);
      chk("f2_write_count", we_seen, 4);
      chk("f2_last_addr", last_addr, 3);
      chk("f2_last_data", last_data, 20'h04004);
      chk("f2_left_unread", q.size(), 6);

      // Frame 3: after the swap the sof=0 leftover is discarded.
      we_seen  = 0;
      err_seen = 0;
      swapped_ftdi = 1'b1;
      step();
      swapped_ftdi = 1'b0;
      wait_empty("f3_drain");
      chk("f3_we", cur_we, 1);
      chk("f3_write_count", we_seen, 1);
      chk("f3_waddr", last_addr, 0);
      chk("f3_wdata", last_data, 20'h088A2);
      chk("f3_sync_err", err_seen, 0);

      // Asynchronous reset while we is high, with a pixel pending.
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      we_seen = 0;
      push_pixel(8'h81, 8'h01, 8'h01);
      repeat (4) step();
      chk("rst_no_write", we_seen, 0);
      chk("rst_no_read", q.size(), 3);
      rst_n = 1'b1;
      push_pixel(8'hC0, 8'h00, 8'h07);
      wait_empty("post_rst_drain");
      chk("post_rst_write_count", we_seen, 1);
      chk("post_rst_waddr", last_addr, 0);
      chk("post_rst_wdata", last_data, 20'h00007);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
